// File: rtl/fifo_sc_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
// Pointer width helper, default thresholds, SOF/EOF bit indices.
package fifo_sc_pkg;

  localparam int SOF_IDX      = 32;
  localparam int EOF_IDX      = 33;
  localparam int AFULL_MARGIN = 4;
  localparam int AEMPTY_DEF   = 4;

  // One extra MSB separates full from empty.
  function automatic int ptr_w(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/fifo_sc_ram.sv
// Simple dual-port storage, WIDTH x 2**DEPTH_LOG2.
// Ports: clk, we/waddr/wdata (sync write), raddr/rdata (async read).
module fifo_sc_ram #(
  parameter int WIDTH      = 36,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sc_param.sv
// Single-clock first-word-fall-through FIFO with valid/ready ports.
// Ports: clk, arst (async high), clear (sync flush), datain,
//   src_rdy_i/dst_rdy_o (write side), dataout, src_rdy_o/dst_rdy_i
//   (read side), space, occupied, almost_full, almost_empty.
// Option FIFO_SC_PACKET_MODE_EN: hold src_rdy_o low until a stored
//   word carries EOF (datain[EOF_BIT]) or the FIFO is full.
module fifo_sc_param
  import fifo_sc_pkg::*;
#(
  parameter int WIDTH         = 36,
  parameter int DEPTH_LOG2    = 9,
  parameter int AFULL_THRESH  =
    (2**DEPTH_LOG2) - AFULL_MARGIN,
  parameter int AEMPTY_THRESH = AEMPTY_DEF,
  parameter int EOF_BIT       = EOF_IDX
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             clear,
  input  logic [WIDTH-1:0] datain,
  input  logic             src_rdy_i,
  output logic             dst_rdy_o,
  output logic [WIDTH-1:0] dataout,
  output logic             src_rdy_o,
  input  logic             dst_rdy_i,
  output logic [15:0]      space,
  output logic [15:0]      occupied,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int PW    = ptr_w(DEPTH_LOG2);
  localparam int DEPTH = 2**DEPTH_LOG2;

  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [PW-1:0] wptr, wptr_n;
  logic [PW-1:0] rptr, rptr_n;
  logic [PW-1:0] occ_n;
  logic          wr_en, rd_en;
  logic          src_n;

  assign wr_en = src_rdy_i & dst_rdy_o;
  assign rd_en = src_rdy_o & dst_rdy_i;

  fifo_sc_ram #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en & ~clear),
    .waddr (wptr[DEPTH_LOG2-1:0]),
    .wdata (datain),
    .raddr (rptr[DEPTH_LOG2-1:0]),
    .rdata (dataout)
  );

  always_comb begin
    wptr_n = wptr;
    rptr_n = rptr;
    if (clear) begin
      wptr_n = '0;
      rptr_n = '0;
    end else begin
      if (wr_en) wptr_n = wptr + PW'(1);
      if (rd_en) rptr_n = rptr + PW'(1);
    end
  end

  // Pointer difference wraps naturally thanks to the extra MSB.
  assign occ_n = wptr_n - rptr_n;

`ifdef FIFO_SC_PACKET_MODE_EN
  logic [PW-1:0] eof_cnt, eof_n;
  logic          eof_wr, eof_rd;

  assign eof_wr = wr_en & datain[EOF_BIT];
  assign eof_rd = rd_en & dataout[EOF_BIT];

  always_comb begin
    eof_n = eof_cnt;
    if (clear) begin
      eof_n = '0;
    end else if (eof_wr & ~eof_rd) begin
      eof_n = eof_cnt + PW'(1);
    end else if (eof_rd & ~eof_wr) begin
      eof_n = eof_cnt - PW'(1);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) eof_cnt <= '0;
    else      eof_cnt <= eof_n;
  end

  assign src_n = (occ_n != '0) &
                 ((eof_n != '0) | (occ_n == DEPTH_P));
`else
  assign src_n = (occ_n != '0);
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wptr         <= '0;
      rptr         <= '0;
      dst_rdy_o    <= 1'b0;
      src_rdy_o    <= 1'b0;
      occupied     <= '0;
      space        <= 16'(DEPTH);
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wptr         <= wptr_n;
      rptr         <= rptr_n;
      dst_rdy_o    <= (occ_n != DEPTH_P);
      src_rdy_o    <= src_n;
      occupied     <= 16'(occ_n);
      space        <= 16'(DEPTH) - 16'(occ_n);
      almost_full  <= (int'(occ_n) >= AFULL_THRESH);
      almost_empty <= (int'(occ_n) <= AEMPTY_THRESH);
    end
  end

endmodule

// File: tb/tb_fifo_sc_param.sv
// Randomized scoreboard bench for fifo_sc_param (16 x 36).
// Queue-based reference model checked every falling edge.
module tb_fifo_sc_param;

  localparam int W  = 36;
  localparam int D  = 16;
  localparam int AF = 12;
  localparam int AE = 4;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          clear = 1'b0;
  logic [W-1:0]  datain = '0;
  logic          src_rdy_i = 1'b0;
  logic          dst_rdy_o;
  logic [W-1:0]  dataout;
  logic          src_rdy_o;
  logic          dst_rdy_i = 1'b0;
  logic [15:0]   space;
  logic [15:0]   occupied;
  logic          almost_full;
  logic          almost_empty;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_sc_param #(
    .WIDTH         (W),
    .DEPTH_LOG2    (4),
    .AFULL_THRESH  (AF),
    .AEMPTY_THRESH (AE),
    .EOF_BIT       (33)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .clear        (clear),
    .datain       (datain),
    .src_rdy_i    (src_rdy_i),
    .dst_rdy_o    (dst_rdy_o),
    .dataout      (dataout),
    .src_rdy_o    (src_rdy_o),
    .dst_rdy_i    (dst_rdy_i),
    .space        (space),
    .occupied     (occupied),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO contents as a plain queue.
  logic [W-1:0] q [$];
  bit           rst_pend = 1'b1;

  function automatic int eofs();
    int n = 0;
    foreach (q[i]) if (q[i][33]) n++;
    return n;
  endfunction

  bit           m_src, m_dst, m_wr, m_rd;
  int           m_cnt;
  logic [W-1:0] m_exp;

  always @(negedge clk) begin
    if (arst) begin
      chk("rst_dst_rdy", 64'(dst_rdy_o), 0);
      chk("rst_src_rdy", 64'(src_rdy_o), 0);
      chk("rst_space", 64'(space), D);
      chk("rst_occupied", 64'(occupied), 0);
      chk("rst_aempty", 64'(almost_empty), 1);
      chk("rst_afull", 64'(almost_full), 0);
      q.delete();
      rst_pend = 1'b1;
    end else begin
      m_cnt = q.size();
      m_dst = !rst_pend && (m_cnt != D);
`ifdef FIFO_SC_PACKET_MODE_EN
      m_src = (m_cnt != 0) && (eofs() != 0 || m_cnt == D);
`else
      m_src = (m_cnt != 0);
`endif
      chk("occupied", 64'(occupied), 64'(m_cnt));
      chk("space", 64'(space), 64'(D - m_cnt));
      chk("src_rdy_o", 64'(src_rdy_o), 64'(m_src));
      chk("dst_rdy_o", 64'(dst_rdy_o), 64'(m_dst));
      chk("almost_full", 64'(almost_full),
          64'(m_cnt >= AF));
      chk("almost_empty", 64'(almost_empty),
          64'(m_cnt <= AE));
      m_wr = src_rdy_i && m_dst;
      m_rd = dst_rdy_i && m_src;
      if (clear) begin
        q.delete();
      end else begin
        if (m_rd) begin
          m_exp = q.pop_front();
          chk("dataout", 64'(dataout), 64'(m_exp));
        end
        if (m_wr) q.push_back(datain);
      end
      rst_pend = 1'b0;
    end
  end

  task automatic cyc(input logic s, input logic [W-1:0] d,
                     input logic r, input logic c);
    src_rdy_i = s;
    datain    = d;
    dst_rdy_i = r;
    clear     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    cyc(0, '0, 0, 1);
    cyc(0, '0, 0, 0);
  endtask

  logic [63:0] rnd;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    arst = 1'b0;
    cyc(0, '0, 0, 0);
    chk("rel_dst_rdy", 64'(dst_rdy_o), 1);

    // Fill 1..17 with no reads; 17th is refused.
    for (int i = 1; i <= 17; i++) cyc(1, W'(i), 0, 0);
    chk("fill_space", 64'(space), 0);
    chk("fill_dst_rdy", 64'(dst_rdy_o), 0);
    chk("fill_occ", 64'(occupied), D);

    // Drain.
    for (int i = 0; i < 18; i++) cyc(0, '0, 1, 0);
`ifndef FIFO_SC_PACKET_MODE_EN
    chk("drain_occ", 64'(occupied), 0);
    chk("drain_src_rdy", 64'(src_rdy_o), 0);
`endif
    flush();

    // Streaming at constant depth 3.
    for (int i = 1; i <= 3; i++)
      cyc(1, W'(i) | 36'h2_0000_0000, 0, 0);
    for (int i = 4; i < 104; i++)
      cyc(1, W'(i) | 36'h2_0000_0000, 1, 0);
    chk("stream_occ", 64'(occupied), 3);
    flush();

    // Clear beats a simultaneous write.
    for (int i = 1; i <= 5; i++) cyc(1, W'(i), 0, 0);
    cyc(1, W'(99), 0, 1);
    chk("clear_occ", 64'(occupied), 0);
    chk("clear_src_rdy", 64'(src_rdy_o), 0);
    cyc(0, '0, 1, 0);
    chk("clear_lost", 64'(occupied), 0);

    // Packet gating: three plain words, then one EOF word.
    for (int i = 1; i <= 3; i++) cyc(1, W'(i), 0, 0);
`ifdef FIFO_SC_PACKET_MODE_EN
    chk("pkt_no_eof", 64'(src_rdy_o), 0);
`endif
    cyc(1, W'(4) | 36'h2_0000_0000, 0, 0);
    chk("pkt_eof", 64'(src_rdy_o), 1);
    for (int i = 0; i < 6; i++) cyc(0, '0, 1, 0);
    flush();

    // Randomized traffic with occasional clear and a reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        arst = 1'b1;
        cyc(0, '0, 0, 0);
        cyc(0, '0, 0, 0);
        arst = 1'b0;
      end
      rnd = {$urandom(), $urandom()};
      cyc(1'($urandom_range(0, 1)), rnd[W-1:0],
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 99) == 0));
    end

    cyc(0, '0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_sc_param.md
FIFO_SC_PARAM -- requirements
Module: fifo_sc_param

Interface
REQ-001 SHALL have parameter WIDTH, default 36, data word width in bits (1..64).
REQ-002 SHALL have parameter DEPTH_LOG2, default 9, storage depth = 2**DEPTH_LOG2 words (2..15).
REQ-003 SHALL have parameter AFULL_THRESH, default 2**DEPTH_LOG2-4, almost_full level in words.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 4, almost_empty level in words.
REQ-005 SHALL have parameter EOF_BIT, default 33, index of the end-of-frame flag inside datain.
REQ-006 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port arst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port clear  input  1  synchronous flush.
REQ-009 SHALL have port datain  input  WIDTH  write data.
REQ-010 SHALL have port src_rdy_i  input  1  upstream has valid datain.
REQ-011 SHALL have port dst_rdy_o  output  1  FIFO can accept a word.
REQ-012 SHALL have port dataout  output  WIDTH  head-of-FIFO data.
REQ-013 SHALL have port src_rdy_o  output  1  dataout valid.
REQ-014 SHALL have port dst_rdy_i  input  1  downstream accepts dataout.
REQ-015 SHALL have ports space and occupied  output  16  free and used words, zero-extended.
REQ-016 SHALL have ports almost_full and almost_empty  output  1  threshold flags.

Function
REQ-017 SHALL write on an edge where src_rdy_i & dst_rdy_o, and read on an edge where src_rdy_o & dst_rdy_i.
REQ-018 SHALL present a word written at edge k on dataout with src_rdy_o=1 after edge k+1 when previously empty (first-word-fall-through, 1-cycle latency).
REQ-019 SHALL sustain one write and one read per cycle; simultaneous write and read leave occupied unchanged.
REQ-020 SHALL drive dst_rdy_o = (occupied != DEPTH) and src_rdy_o = (occupied != 0), both registered outputs.
REQ-021 SHALL NOT accept a write when full, even if a read occurs in the same cycle.
REQ-022 SHALL keep space + occupied = DEPTH at all times.
REQ-023 SHALL wrap read/write pointers modulo DEPTH with an extra MSB to distinguish full from empty.
REQ-024 SHALL assert almost_full when occupied >= AFULL_THRESH and almost_empty when occupied <= AEMPTY_THRESH, both registered.
REQ-025 SHALL give clear priority over a same-cycle write or read: the next cycle has occupied=0 and src_rdy_o=0, and the write is discarded.
REQ-026 SHALL preserve word order exactly; dataout is don't-care while src_rdy_o=0.

Reset
REQ-027 SHALL, while arst=1, force pointers and occupied to 0, space to DEPTH, src_rdy_o=0, almost_empty=1, almost_full=0, dst_rdy_o=0.
REQ-028 SHALL raise dst_rdy_o on the first clk edge after arst deasserts; assertion of arst mid-transfer discards all contents.

Configuration
REQ-029 SHALL support macro FIFO_SC_PACKET_MODE_EN; when undefined, src_rdy_o follows REQ-020.
REQ-030 SHALL, with FIFO_SC_PACKET_MODE_EN defined, keep a stored-EOF counter (+1 on write with datain[EOF_BIT]=1, -1 on read with dataout[EOF_BIT]=1, both same cycle = no change), and drive src_rdy_o = (occupied != 0) & (counter != 0 | occupied == DEPTH).
REQ-031 SHALL clear the EOF counter on arst and clear.

Structure
REQ-032 SHALL place the pointer-width function, the default threshold constants and the SOF/EOF bit-index constants (32/33) in the shared package fifo_sc_pkg.
REQ-033 SHALL use one sub-module fifo_sc_ram: simple dual-port WIDTH x DEPTH, synchronous write, asynchronous read.

Verification (WIDTH=36, DEPTH_LOG2=4, AFULL_THRESH=12, AEMPTY_THRESH=4)
REQ-034 SHALL check reset: arst=1 -> dst_rdy_o=0, src_rdy_o=0, space=16, occupied=0; release -> dst_rdy_o=1 on the next edge.
REQ-035 SHALL check fill: write 1..16 with dst_rdy_i=0 -> almost_full from the 12th word, dst_rdy_o=0 after the 16th, space=0, and a 17th word is not accepted.
REQ-036 SHALL check drain: dst_rdy_i=1 -> dataout 1..16 in order, then src_rdy_o=0 and occupied=0.
REQ-037 SHALL check streaming: hold occupied=3 with read and write every cycle for 100 cycles -> occupied constant at 3, data incrementing without gaps.
REQ-038 SHALL check clear: 5 words stored, clear=1 together with a write -> next cycle occupied=0, src_rdy_o=0, and the write is lost.
REQ-039 SHALL check packet mode (FIFO_SC_PACKET_MODE_EN): write 3 words with bit33=0 -> src_rdy_o stays 0; write a 4th with bit33=1 -> src_rdy_o=1 after the next edge; 16 words without EOF -> src_rdy_o=1.
